// File: rtl/arb_req_client.sv
// arb_req_client: requester-side companion to the round-robin req/gnt arbiter.
// Holds NUM_REQ saturating pending-transaction counters, drives req while work is
// pending, consumes one-hot grants, and flags starvation per client.
// Ports:
//   clk      - clock, all state on posedge
//   rst      - asynchronous active-low reset
//   push     - per-client enqueue strobe
//   push_ok  - client can accept a push (pending count below max)
//   req      - request lines to the arbiter
//   gnt      - grant lines from the arbiter (one-hot or zero)
//   served   - registered pulse one cycle after a grant is consumed
//   pending  - flattened pending counts, client i at [i*CNT_W +: CNT_W]
//   starve   - client has waited at least STARVE_LIMIT cycles
//   err      - sticky grant-protocol error
// Optional: define ARB_GNT_CHECK_EN to enable the grant protocol checker;
// otherwise err is tied low.
module arb_req_client #(
    parameter int NUM_REQ      = 4,
    parameter int CNT_W        = 3,
    parameter int WAIT_W       = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       push,
    output logic [NUM_REQ-1:0]       push_ok,
    output logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       served,
    output logic [NUM_REQ*CNT_W-1:0] pending,
    output logic [NUM_REQ-1:0]       starve,
    output logic                     err
);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;
    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);
    logic [NUM_REQ-1:0] take;
`ifdef ARB_GNT_CHECK_EN
    localparam logic [NUM_REQ-1:0] ONE = 1;
    logic multi, stray, err_q;
    // more than one grant bit: no bit is trusted, so nothing is consumed
    assign multi = |(gnt & (gnt - ONE));
    assign stray = |(gnt & ~req);
    assign take  = multi ? '0 : gnt & req;
    assign err   = err_q;
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            err_q <= 1'b0;
        else if (multi || stray)
            err_q <= 1'b1;
`else
    assign take = gnt & req;
    assign err  = 1'b0;
`endif
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cli
        logic [CNT_W-1:0]  cnt;
        logic [WAIT_W-1:0] wcnt, wnext;
        logic              srv_q, stv_q;
        assign req[i]                    = cnt != '0;
        assign push_ok[i]                = cnt != CNT_MAX;
        assign pending[i*CNT_W +: CNT_W] = cnt;
        assign served[i]                 = srv_q;
        assign starve[i]                 = stv_q;
        always_comb
            wnext = (!req[i] || take[i]) ? '0 :
                    (gnt[i] || wcnt == WAIT_MAX) ? wcnt : wcnt + 1'b1;
        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                cnt   <= '0;
                wcnt  <= '0;
                srv_q <= 1'b0;
                stv_q <= 1'b0;
            end else begin
                cnt   <= cnt + CNT_W'(push[i] & push_ok[i]) - CNT_W'(take[i]);
                wcnt  <= wnext;
                srv_q <= take[i];
                // tracks the wait count being loaded this edge
                stv_q <= wnext >= LIMIT;
            end
    end
endmodule

// File: tb/tb_arb_req_client.sv
// tb_arb_req_client: random and directed checks of arb_req_client against a behavioural model.
module tb_arb_req_client;
    localparam int N = 4;
    localparam int CW = 3;
    localparam int MAXC = 7;
    localparam int MAXW = 255;
    localparam int LIM = 16;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0] push = '0, gnt = '0;
    logic [N-1:0] push_ok, req, served, starve;
    logic [N*CW-1:0] pending;
    logic err;
    int vectors = 0;
    int miscompares = 0;
    int m_cnt[N];
    int m_w[N];
    bit [N-1:0] m_srv, m_stv;
    bit m_err;

    arb_req_client dut (
        .clk(clk), .rst(rst), .push(push), .push_ok(push_ok), .req(req),
        .gnt(gnt), .served(served), .pending(pending), .starve(starve), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] m_req();
        for (int i = 0; i < N; i++) m_req[i] = m_cnt[i] != 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_w[i] = 0;
        end
        m_srv = '0;
        m_stv = '0;
        m_err = 0;
    endtask

    task automatic m_step(input logic [N-1:0] p, input logic [N-1:0] g);
        logic [N-1:0] rq;
        int ng;
        bit valid;
        rq = m_req();
        ng = $countones(g);
`ifdef ARB_GNT_CHECK_EN
        if (ng > 1 || (g & ~rq) != 0) m_err = 1;
`endif
        for (int i = 0; i < N; i++) begin
            valid = g[i] && rq[i];
`ifdef ARB_GNT_CHECK_EN
            if (ng > 1) valid = 0;
`endif
            if (p[i] && m_cnt[i] < MAXC) m_cnt[i]++;
            if (valid) m_cnt[i]--;
            if (!rq[i] || valid) m_w[i] = 0;
            else if (!g[i]) m_w[i] = (m_w[i] < MAXW) ? m_w[i] + 1 : MAXW;
            m_srv[i] = valid;
            m_stv[i] = m_w[i] >= LIM;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [N*CW-1:0] ep;
        logic [N-1:0] eok;
        for (int i = 0; i < N; i++) begin
            ep[i*CW +: CW] = CW'(m_cnt[i]);
            eok[i] = m_cnt[i] != MAXC;
        end
        chk("pending", 32'(pending), 32'(ep));
        chk("req", 32'(req), 32'(m_req()));
        chk("push_ok", 32'(push_ok), 32'(eok));
        chk("served", 32'(served), 32'(m_srv));
        chk("starve", 32'(starve), 32'(m_stv));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic cycle(input logic [N-1:0] p, input logic [N-1:0] g);
        push = p;
        gnt = g;
        @(posedge clk);
        m_step(p, g);
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [N-1:0] pick_gnt();
        logic [N-1:0] rq;
        int s;
        rq = m_req();
        s = $urandom % N;
        pick_gnt = '0;
        for (int k = 0; k < N; k++)
            if (pick_gnt == '0 && rq[(s + k) % N]) pick_gnt[(s + k) % N] = 1'b1;
    endfunction

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        compare_all();
        chk("lit_reset_req", 32'(req), 32'h0);
        chk("lit_reset_push_ok", 32'(push_ok), 32'hF);
        // single round trip on client 2
        cycle(4'b0100, 4'b0000);
        chk("lit_rt_req", 32'(req), 32'h4);
        cycle(4'b0000, m_req());
        chk("lit_rt_served", 32'(served), 32'h4);
        chk("lit_rt_req_drop", 32'(req), 32'h0);
        cycle(4'b0000, 4'b0000);
        chk("lit_rt_served_end", 32'(served), 32'h0);
        // fill client 0 to max
        for (int k = 1; k <= 9; k++) begin
            cycle(4'b0001, 4'b0000);
            if (k == 7) chk("lit_fill_ok_low", 32'(push_ok[0]), 32'h0);
        end
        chk("lit_fill_pending", 32'(pending[2:0]), 32'h7);
        chk("lit_fill_err", 32'(err), 32'h0);
        repeat (7) cycle(4'b0000, 4'b0001);
        chk("lit_drain", 32'(pending[2:0]), 32'h0);
        // push and grant together on client 3
        repeat (2) cycle(4'b1000, 4'b0000);
        cycle(4'b1000, 4'b1000);
        chk("lit_pg_pending", 32'(pending[11:9]), 32'h2);
        chk("lit_pg_served", 32'(served), 32'h8);
        chk("lit_pg_req", 32'(req[3]), 32'h1);
        repeat (2) cycle(4'b0000, 4'b1000);
        // starvation on client 1
        cycle(4'b0010, 4'b0000);
        for (int k = 1; k <= 19; k++) begin
            cycle(4'b0000, 4'b0000);
            if (k == 15) chk("lit_starve_early", 32'(starve[1]), 32'h0);
            if (k == 16) chk("lit_starve_set", 32'(starve[1]), 32'h1);
        end
        cycle(4'b0000, 4'b0010);
        chk("lit_starve_clear", 32'(starve[1]), 32'h0);
        // protocol: double grant then stray grant
        cycle(4'b0011, 4'b0000);
        cycle(4'b0000, 4'b0011);
`ifdef ARB_GNT_CHECK_EN
        chk("lit_proto_err", 32'(err), 32'h1);
        chk("lit_proto_served", 32'(served), 32'h0);
`else
        chk("lit_proto_err", 32'(err), 32'h0);
        chk("lit_proto_served", 32'(served), 32'h3);
`endif
        cycle(4'b0000, 4'b1000);
        chk("lit_stray_served", 32'(served[3]), 32'h0);
        chk("lit_stray_pending", 32'(pending[11:9]), 32'h0);
`ifdef ARB_GNT_CHECK_EN
        chk("lit_stray_err", 32'(err), 32'h1);
`else
        chk("lit_stray_err", 32'(err), 32'h0);
`endif
        // mid-run asynchronous reset with client 1 at 3
        while (m_req() != 0) cycle(4'b0000, pick_gnt());
        repeat (3) cycle(4'b0010, 4'b0000);
        chk("lit_pre_reset", 32'(pending[5:3]), 32'h3);
        #1 rst = 1'b0;
        m_reset();
        #1;
        compare_all();
        chk("lit_mid_reset_pending", 32'(pending), 32'h0);
        chk("lit_mid_reset_push_ok", 32'(push_ok), 32'hF);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            int r;
            logic [N-1:0] g;
            r = $urandom % 8;
            g = (r < 2) ? '0 : (r < 6) ? pick_gnt() :
                (r == 6) ? N'(1 << ($urandom % N)) : N'($urandom);
            cycle(N'($urandom), g);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
